// File: rtl/arp_recv.sv
// Receive-side ARP parser: validates ARP frames aimed at the local IP.
// It posts a reply request for each ARP request and a cache write for every accepted frame.
module arp_recv #(
  parameter bit CHECK_DEST_MAC = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] local_IP_in,
  input  logic [47:0] local_MAC_in,
  input  logic [31:0] rx_tdata,
  input  logic [3:0]  rx_tkeep,
  input  logic        rx_tvalid,
  input  logic        rx_tlast,
  output logic        rx_tready,
  output logic [31:0] remote_ip_addr_out,
  output logic [47:0] remote_mac_addr_out,
  output logic        arp_reply_out,
  input  logic        arp_reply_ack_in,
  output logic        cache_wr_en_out,
  output logic [31:0] cache_ip_addr_out,
  output logic [47:0] cache_mac_addr_out,
  output logic [15:0] arp_frame_cnt_out,
  output logic [15:0] arp_drop_cnt_out,
  output logic [1:0]  fsm_state
);

  // Handshake: a beat transfers on a rising edge where rx_tvalid and rx_tready are both 1;
  // arp_reply_out is a level held until a one-cycle arp_reply_ack_in.
  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, PAD = 2'd2, DROP = 2'd3} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        da_bc;
  logic        da_uc;
  logic        req_q;
  logic [47:0] sha_q;
  logic [31:0] spa_q;

  logic beat;
  logic pending;
  logic w0_ok;
  logic hdr_ok;
  logic accept;
  logic drop;
  logic unused_keep;

  assign fsm_state   = state;
  assign unused_keep = ^rx_tkeep[1:0];

  always_comb begin
    beat    = rx_tvalid & rx_tready;
    pending = arp_reply_out & ~arp_reply_ack_in;
    w0_ok   = !CHECK_DEST_MAC || (rx_tdata == 32'hFFFF_FFFF) ||
              (rx_tdata == local_MAC_in[47:16]);
    hdr_ok  = 1'b1;
    case (cnt)
      // Lower DA half must complete the same match (broadcast or local) as the upper half.
      4'd1:    hdr_ok = !CHECK_DEST_MAC ||
                        (da_bc && rx_tdata[31:16] == 16'hFFFF) ||
                        (da_uc && rx_tdata[31:16] == local_MAC_in[15:0]);
      4'd3:    hdr_ok = (rx_tdata == 32'h0806_0001);
      4'd4:    hdr_ok = (rx_tdata == 32'h0800_0604);
      4'd5:    hdr_ok = (rx_tdata[31:16] == 16'd1) || (rx_tdata[31:16] == 16'd2);
      4'd9:    hdr_ok = (rx_tdata[15:0] == local_IP_in[31:16]);
      4'd10:   hdr_ok = (rx_tdata[31:16] == local_IP_in[15:0]) && (rx_tkeep[3:2] == 2'b11);
      default: hdr_ok = 1'b1;
    endcase
    accept = beat && rx_tlast &&
             ((state == HDR && cnt == 4'd10 && hdr_ok) || state == PAD);
    drop   = beat && rx_tlast && !accept;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state               <= IDLE;
      cnt                 <= 4'd0;
      da_bc               <= 1'b0;
      da_uc               <= 1'b0;
      req_q               <= 1'b0;
      sha_q               <= 48'd0;
      spa_q               <= 32'd0;
      rx_tready           <= 1'b0;
      remote_ip_addr_out  <= 32'd0;
      remote_mac_addr_out <= 48'd0;
      arp_reply_out       <= 1'b0;
      cache_wr_en_out     <= 1'b0;
      cache_ip_addr_out   <= 32'd0;
      cache_mac_addr_out  <= 48'd0;
      arp_frame_cnt_out   <= 16'd0;
      arp_drop_cnt_out    <= 16'd0;
    end else begin
      rx_tready       <= 1'b1;
      cache_wr_en_out <= 1'b0;
      if (arp_reply_ack_in) arp_reply_out <= 1'b0;

      if (accept) begin
        cache_wr_en_out    <= 1'b1;
        cache_ip_addr_out  <= spa_q;
        cache_mac_addr_out <= sha_q;
        arp_frame_cnt_out  <= arp_frame_cnt_out + 16'd1;
        // A request arriving while a reply is still pending is cached but not answered.
        if (req_q && !pending) begin
          arp_reply_out       <= 1'b1;
          remote_ip_addr_out  <= spa_q;
          remote_mac_addr_out <= sha_q;
        end
      end
      if (drop) arp_drop_cnt_out <= arp_drop_cnt_out + 16'd1;

      if (beat) begin
        if (state == HDR) begin
          case (cnt)
            4'd5:    begin req_q <= (rx_tdata[31:16] == 16'd1); sha_q[47:32] <= rx_tdata[15:0]; end
            4'd6:    sha_q[31:0] <= rx_tdata;
            4'd7:    spa_q <= rx_tdata;
            default: ;
          endcase
        end
        if (rx_tlast) begin
          state <= IDLE;
          cnt   <= 4'd0;
        end else begin
          case (state)
            IDLE: begin
              da_bc <= (rx_tdata == 32'hFFFF_FFFF);
              da_uc <= (rx_tdata == local_MAC_in[47:16]);
              cnt   <= 4'd1;
              state <= w0_ok ? HDR : DROP;
            end
            HDR: begin
              if (!hdr_ok)           state <= DROP;
              else if (cnt == 4'd10) state <= PAD;
              else                   cnt   <= cnt + 4'd1;
            end
            default: ;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_arp_recv.sv
// Directed bench for arp_recv: requests, replies, drops, padding, back-to-back and mid-frame reset.
module tb_arp_recv;

  localparam logic [31:0] LIP   = 32'hC0A8_0102;
  localparam logic [47:0] LMAC  = 48'h0200_0000_0001;
  localparam logic [47:0] BC    = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] SHA_A = 48'h0011_2233_4455;
  localparam logic [31:0] SPA_A = 32'hC0A8_010A;
  localparam logic [47:0] SHA_B = 48'h00AA_BBCC_DDEE;
  localparam logic [31:0] SPA_B = 32'hC0A8_010B;
  localparam logic [47:0] SHA_R = 48'h6655_4433_2211;
  localparam logic [31:0] SPA_R = 32'h0A00_0005;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] rx_tdata;
  logic [3:0]  rx_tkeep;
  logic        rx_tvalid;
  logic        rx_tlast;
  logic        rx_tready;
  logic [31:0] remote_ip_addr_out;
  logic [47:0] remote_mac_addr_out;
  logic        arp_reply_out;
  logic        arp_reply_ack_in;
  logic        cache_wr_en_out;
  logic [31:0] cache_ip_addr_out;
  logic [47:0] cache_mac_addr_out;
  logic [15:0] arp_frame_cnt_out;
  logic [15:0] arp_drop_cnt_out;
  logic [1:0]  fsm_state;

  logic [31:0] fbuf [0:15];
  logic [3:0]  kbuf [0:15];
  logic [15:0] exp_frame;
  logic [15:0] exp_drop;
  int checks = 0;
  int errors = 0;

  arp_recv #(.CHECK_DEST_MAC(1'b1)) dut (
    .clk(clk), .reset(reset), .local_IP_in(LIP), .local_MAC_in(LMAC),
    .rx_tdata(rx_tdata), .rx_tkeep(rx_tkeep), .rx_tvalid(rx_tvalid), .rx_tlast(rx_tlast),
    .rx_tready(rx_tready), .remote_ip_addr_out(remote_ip_addr_out),
    .remote_mac_addr_out(remote_mac_addr_out), .arp_reply_out(arp_reply_out),
    .arp_reply_ack_in(arp_reply_ack_in), .cache_wr_en_out(cache_wr_en_out),
    .cache_ip_addr_out(cache_ip_addr_out), .cache_mac_addr_out(cache_mac_addr_out),
    .arp_frame_cnt_out(arp_frame_cnt_out), .arp_drop_cnt_out(arp_drop_cnt_out),
    .fsm_state(fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // driver tasks
  task automatic build_arp(input logic [47:0] da, input logic [15:0] etype, input logic [15:0] oper,
                           input logic [47:0] sha, input logic [31:0] spa, input logic [31:0] tpa);
    for (int i = 0; i < 16; i++) begin fbuf[i] = 32'd0; kbuf[i] = 4'hF; end
    fbuf[0]  = da[47:16];
    fbuf[1]  = {da[15:0], 16'h0200};
    fbuf[2]  = 32'h0000_0077;
    fbuf[3]  = {etype, 16'h0001};
    fbuf[4]  = {16'h0800, 8'd6, 8'd4};
    fbuf[5]  = {oper, sha[47:32]};
    fbuf[6]  = sha[31:0];
    fbuf[7]  = spa;
    fbuf[8]  = 32'd0;
    fbuf[9]  = {16'h0000, tpa[31:16]};
    fbuf[10] = {tpa[15:0], 16'h0000};
  endtask

  // Bubbles carry tlast=1 with tvalid=0 so that a frozen FSM is actually tested.
  task automatic send_frame(input int len, input bit bubbles, input bit ack_last);
    for (int i = 0; i < len; i++) begin
      if (bubbles && (i % 2 == 1)) begin
        rx_tvalid = 1'b0; rx_tlast = 1'b1; rx_tdata = 32'hDEAD_BEEF;
        @(posedge clk); #1;
      end
      rx_tvalid = 1'b1; rx_tdata = fbuf[i]; rx_tkeep = kbuf[i];
      rx_tlast = (i == len - 1);
      arp_reply_ack_in = ack_last && (i == len - 1);
      @(posedge clk); #1;
    end
    rx_tvalid = 1'b0; rx_tlast = 1'b0; arp_reply_ack_in = 1'b0;
  endtask

  task automatic do_ack;
    arp_reply_ack_in = 1'b1;
    @(posedge clk); #1;
    arp_reply_ack_in = 1'b0;
  endtask

  task automatic test_reset;
    checks++; if (rx_tready !== 1'b0) begin errors++; $display("FAIL rst_tready got=%0h exp=0", rx_tready); end
    checks++; if (arp_reply_out !== 1'b0) begin errors++; $display("FAIL rst_reply got=%0h exp=0", arp_reply_out); end
    checks++; if (cache_wr_en_out !== 1'b0) begin errors++; $display("FAIL rst_wr got=%0h exp=0", cache_wr_en_out); end
    checks++; if (remote_ip_addr_out !== 32'd0) begin errors++; $display("FAIL rst_rip got=%0h exp=0", remote_ip_addr_out); end
    checks++; if (arp_frame_cnt_out !== 16'd0) begin errors++; $display("FAIL rst_fcnt got=%0h exp=0", arp_frame_cnt_out); end
    checks++; if (arp_drop_cnt_out !== 16'd0) begin errors++; $display("FAIL rst_dcnt got=%0h exp=0", arp_drop_cnt_out); end
    checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL rst_state got=%0h exp=0", fsm_state); end
  endtask

  task automatic test_request;
    build_arp(BC, 16'h0806, 16'd1, SHA_A, SPA_A, LIP);
    send_frame(11, 1'b0, 1'b0);
    exp_frame = exp_frame + 16'd1;
    checks++; if (arp_reply_out !== 1'b1) begin errors++; $display("FAIL req_reply got=%0h exp=1", arp_reply_out); end
    checks++; if (remote_ip_addr_out !== 32'hC0A8010A) begin errors++; $display("FAIL req_rip got=%0h exp=c0a8010a", remote_ip_addr_out); end
    checks++; if (remote_mac_addr_out !== 48'h001122334455) begin errors++; $display("FAIL req_rmac got=%0h exp=001122334455", remote_mac_addr_out); end
    checks++; if (cache_wr_en_out !== 1'b1) begin errors++; $display("FAIL req_wr got=%0h exp=1", cache_wr_en_out); end
    checks++; if (cache_ip_addr_out !== SPA_A) begin errors++; $display("FAIL req_cip got=%0h exp=%0h", cache_ip_addr_out, SPA_A); end
    checks++; if (cache_mac_addr_out !== SHA_A) begin errors++; $display("FAIL req_cmac got=%0h exp=%0h", cache_mac_addr_out, SHA_A); end
    checks++; if (arp_frame_cnt_out !== exp_frame) begin errors++; $display("FAIL req_fcnt got=%0h exp=%0h", arp_frame_cnt_out, exp_frame); end
    checks++; if (arp_drop_cnt_out !== exp_drop) begin errors++; $display("FAIL req_dcnt got=%0h exp=%0h", arp_drop_cnt_out, exp_drop); end
    idle(1);
    checks++; if (cache_wr_en_out !== 1'b0) begin errors++; $display("FAIL req_wr_pulse got=%0h exp=0", cache_wr_en_out); end
    checks++; if (cache_ip_addr_out !== SPA_A) begin errors++; $display("FAIL req_cip_hold got=%0h exp=%0h", cache_ip_addr_out, SPA_A); end
    idle(3);
    checks++; if (arp_reply_out !== 1'b1) begin errors++; $display("FAIL req_reply_held got=%0h exp=1", arp_reply_out); end
    do_ack;
    checks++; if (arp_reply_out !== 1'b0) begin errors++; $display("FAIL req_ack_clear got=%0h exp=0", arp_reply_out); end
    checks++; if (remote_ip_addr_out !== SPA_A) begin errors++; $display("FAIL req_rip_hold got=%0h exp=%0h", remote_ip_addr_out, SPA_A); end
  endtask

  task automatic test_padded_bubbles;
    build_arp(BC, 16'h0806, 16'd1, SHA_A, SPA_A, LIP);
    send_frame(15, 1'b1, 1'b0);
    exp_frame = exp_frame + 16'd1;
    checks++; if (arp_reply_out !== 1'b1) begin errors++; $display("FAIL pad_reply got=%0h exp=1", arp_reply_out); end
    checks++; if (cache_wr_en_out !== 1'b1) begin errors++; $display("FAIL pad_wr got=%0h exp=1", cache_wr_en_out); end
    checks++; if (remote_mac_addr_out !== SHA_A) begin errors++; $display("FAIL pad_rmac got=%0h exp=%0h", remote_mac_addr_out, SHA_A); end
    checks++; if (arp_frame_cnt_out !== exp_frame) begin errors++; $display("FAIL pad_fcnt got=%0h exp=%0h", arp_frame_cnt_out, exp_frame); end
    idle(1);
    checks++; if (cache_wr_en_out !== 1'b0) begin errors++; $display("FAIL pad_wr_pulse got=%0h exp=0", cache_wr_en_out); end
    do_ack;
  endtask

  task automatic test_drops;
    for (int k = 0; k < 6; k++) begin
      int len;
      len = 11;
      build_arp(BC, 16'h0806, 16'd1, SHA_B, SPA_B, LIP);
      case (k)
        0: build_arp(BC, 16'h0806, 16'd1, SHA_B, SPA_B, 32'hC0A8_0103);
        1: build_arp(BC, 16'h0800, 16'd1, SHA_B, SPA_B, LIP);
        2: len = 8;
        3: build_arp(48'h0200_0000_0099, 16'h0806, 16'd1, SHA_B, SPA_B, LIP);
        4: kbuf[10] = 4'b1000;
        default: len = 1;
      endcase
      send_frame(len, 1'b0, 1'b0);
      exp_drop = exp_drop + 16'd1;
      checks++; if (cache_wr_en_out !== 1'b0) begin errors++; $display("FAIL drop%0d_wr got=%0h exp=0", k, cache_wr_en_out); end
      checks++; if (arp_reply_out !== 1'b0) begin errors++; $display("FAIL drop%0d_reply got=%0h exp=0", k, arp_reply_out); end
      checks++; if (arp_drop_cnt_out !== exp_drop) begin errors++; $display("FAIL drop%0d_dcnt got=%0h exp=%0h", k, arp_drop_cnt_out, exp_drop); end
      checks++; if (arp_frame_cnt_out !== exp_frame) begin errors++; $display("FAIL drop%0d_fcnt got=%0h exp=%0h", k, arp_frame_cnt_out, exp_frame); end
    end
    build_arp(LMAC, 16'h0806, 16'd1, SHA_B, SPA_B, LIP);
    send_frame(11, 1'b0, 1'b0);
    exp_frame = exp_frame + 16'd1;
    checks++; if (cache_wr_en_out !== 1'b1) begin errors++; $display("FAIL post_drop_wr got=%0h exp=1", cache_wr_en_out); end
    checks++; if (cache_ip_addr_out !== SPA_B) begin errors++; $display("FAIL post_drop_cip got=%0h exp=%0h", cache_ip_addr_out, SPA_B); end
    checks++; if (remote_ip_addr_out !== SPA_B) begin errors++; $display("FAIL post_drop_rip got=%0h exp=%0h", remote_ip_addr_out, SPA_B); end
    checks++; if (arp_frame_cnt_out !== exp_frame) begin errors++; $display("FAIL post_drop_fcnt got=%0h exp=%0h", arp_frame_cnt_out, exp_frame); end
    do_ack;
  endtask

  task automatic test_reply;
    build_arp(BC, 16'h0806, 16'd2, SHA_R, SPA_R, LIP);
    send_frame(11, 1'b0, 1'b0);
    exp_frame = exp_frame + 16'd1;
    checks++; if (cache_wr_en_out !== 1'b1) begin errors++; $display("FAIL rep_wr got=%0h exp=1", cache_wr_en_out); end
    checks++; if (cache_ip_addr_out !== 32'h0A000005) begin errors++; $display("FAIL rep_cip got=%0h exp=0a000005", cache_ip_addr_out); end
    checks++; if (cache_mac_addr_out !== SHA_R) begin errors++; $display("FAIL rep_cmac got=%0h exp=%0h", cache_mac_addr_out, SHA_R); end
    checks++; if (arp_reply_out !== 1'b0) begin errors++; $display("FAIL rep_reply got=%0h exp=0", arp_reply_out); end
    checks++; if (remote_ip_addr_out !== SPA_B) begin errors++; $display("FAIL rep_rip_hold got=%0h exp=%0h", remote_ip_addr_out, SPA_B); end
    checks++; if (arp_frame_cnt_out !== exp_frame) begin errors++; $display("FAIL rep_fcnt got=%0h exp=%0h", arp_frame_cnt_out, exp_frame); end
  endtask

  task automatic test_back_to_back;
    build_arp(BC, 16'h0806, 16'd1, SHA_A, SPA_A, LIP);
    send_frame(11, 1'b0, 1'b0);
    checks++; if (cache_ip_addr_out !== SPA_A) begin errors++; $display("FAIL b2b_first_cip got=%0h exp=%0h", cache_ip_addr_out, SPA_A); end
    build_arp(BC, 16'h0806, 16'd1, SHA_B, SPA_B, LIP);
    send_frame(11, 1'b0, 1'b0);
    exp_frame = exp_frame + 16'd2;
    checks++; if (remote_ip_addr_out !== SPA_A) begin errors++; $display("FAIL b2b_rip got=%0h exp=%0h", remote_ip_addr_out, SPA_A); end
    checks++; if (remote_mac_addr_out !== SHA_A) begin errors++; $display("FAIL b2b_rmac got=%0h exp=%0h", remote_mac_addr_out, SHA_A); end
    checks++; if (cache_wr_en_out !== 1'b1) begin errors++; $display("FAIL b2b_wr got=%0h exp=1", cache_wr_en_out); end
    checks++; if (cache_ip_addr_out !== SPA_B) begin errors++; $display("FAIL b2b_cip got=%0h exp=%0h", cache_ip_addr_out, SPA_B); end
    checks++; if (arp_reply_out !== 1'b1) begin errors++; $display("FAIL b2b_reply got=%0h exp=1", arp_reply_out); end
    checks++; if (arp_frame_cnt_out !== exp_frame) begin errors++; $display("FAIL b2b_fcnt got=%0h exp=%0h", arp_frame_cnt_out, exp_frame); end
    do_ack;
    build_arp(BC, 16'h0806, 16'd1, SHA_A, SPA_A, LIP);
    send_frame(11, 1'b0, 1'b0);
    build_arp(BC, 16'h0806, 16'd1, SHA_B, SPA_B, LIP);
    send_frame(11, 1'b0, 1'b1);
    exp_frame = exp_frame + 16'd2;
    checks++; if (remote_ip_addr_out !== SPA_B) begin errors++; $display("FAIL ackx_rip got=%0h exp=%0h", remote_ip_addr_out, SPA_B); end
    checks++; if (remote_mac_addr_out !== SHA_B) begin errors++; $display("FAIL ackx_rmac got=%0h exp=%0h", remote_mac_addr_out, SHA_B); end
    checks++; if (arp_reply_out !== 1'b1) begin errors++; $display("FAIL ackx_reply got=%0h exp=1", arp_reply_out); end
    checks++; if (arp_frame_cnt_out !== exp_frame) begin errors++; $display("FAIL ackx_fcnt got=%0h exp=%0h", arp_frame_cnt_out, exp_frame); end
    do_ack;
    checks++; if (arp_reply_out !== 1'b0) begin errors++; $display("FAIL ackx_clear got=%0h exp=0", arp_reply_out); end
  endtask

  task automatic test_reset_mid_frame;
    build_arp(BC, 16'h0806, 16'd1, SHA_A, SPA_A, LIP);
    for (int i = 0; i < 6; i++) begin
      rx_tvalid = 1'b1; rx_tdata = fbuf[i]; rx_tkeep = 4'hF; rx_tlast = 1'b0;
      @(posedge clk); #1;
    end
    reset = 1'b1; rx_tvalid = 1'b0;
    idle(2);
    exp_frame = 16'd0; exp_drop = 16'd0;
    checks++; if (arp_frame_cnt_out !== exp_frame) begin errors++; $display("FAIL mid_rst_fcnt got=%0h exp=0", arp_frame_cnt_out); end
    checks++; if (fsm_state !== 2'd0) begin errors++; $display("FAIL mid_rst_state got=%0h exp=0", fsm_state); end
    reset = 1'b0;
    idle(2);
    checks++; if (rx_tready !== 1'b1) begin errors++; $display("FAIL mid_tready got=%0h exp=1", rx_tready); end
    build_arp(BC, 16'h0806, 16'd1, SHA_B, SPA_B, LIP);
    send_frame(11, 1'b0, 1'b0);
    exp_frame = exp_frame + 16'd1;
    checks++; if (arp_frame_cnt_out !== exp_frame) begin errors++; $display("FAIL mid_fcnt got=%0h exp=%0h", arp_frame_cnt_out, exp_frame); end
    checks++; if (arp_drop_cnt_out !== exp_drop) begin errors++; $display("FAIL mid_dcnt got=%0h exp=%0h", arp_drop_cnt_out, exp_drop); end
    checks++; if (arp_reply_out !== 1'b1) begin errors++; $display("FAIL mid_reply got=%0h exp=1", arp_reply_out); end
    checks++; if (remote_ip_addr_out !== SPA_B) begin errors++; $display("FAIL mid_rip got=%0h exp=%0h", remote_ip_addr_out, SPA_B); end
    do_ack;
  endtask

  initial begin
    reset = 1'b1; rx_tdata = 32'd0; rx_tkeep = 4'hF; rx_tvalid = 1'b0; rx_tlast = 1'b0;
    arp_reply_ack_in = 1'b0; exp_frame = 16'd0; exp_drop = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    test_reset;
    reset = 1'b0;
    idle(2);
    test_request;
    test_padded_bubbles;
    test_drops;
    test_reply;
    test_back_to_back;
    test_reset_mid_frame;
    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
